lcd_scanout: RTL



---
 rtl/lcd_scanout.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lcd_scanout.sv
// LCD scan-out engine: walks the VRAM read port and emits a VGA-style raster
// with the 640x64 LCD bitmap scaled vertically into a window starting at V_TOP.
module lcd_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_SCALE  = 4,
  parameter int V_TOP    = 112
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] vram_rp_a,
  input  logic [3:0]  vram_rp_do,
  input  logic        lcd_on,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        pix,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA       = 10'(H_ACTIVE);
  localparam logic [9:0] VA       = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WIN_BEG  = 10'(V_TOP);
  localparam logic [9:0] WIN_END  = 10'(V_TOP + 64 * V_SCALE);
  // Row/sub clear on the last edge before the window so line V_TOP starts at row 0.
  localparam logic [9:0] CLR_LINE = 10'((V_TOP == 0) ? V_TOTAL - 1 : V_TOP - 1);
  localparam logic [2:0] SUB_LAST = 3'(V_SCALE - 1);

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       win;
    logic [1:0] sel;
  } ctl_t;

  logic [9:0]      hcnt, vcnt;
  logic [2:0]      sub;
  logic [5:0]      row;
  logic            line_end, win_line, in_win;
  logic            lcd_on_frame;
  ctl_t            ctl0;
  ctl_t [2:1]      ctl_pipe;

  assign line_end = (hcnt == H_LAST);
  assign win_line = (vcnt >= WIN_BEG) && (vcnt < WIN_END);
  assign in_win   = win_line && (hcnt < HA);

  // Stage 0: raster position and LCD row tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
      sub  <= '0;
      row  <= '0;
    end else begin
      hcnt <= line_end ? '0 : hcnt + 10'd1;
      if (line_end) begin
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        if (vcnt == CLR_LINE) begin
          sub <= '0;
          row <= '0;
        end else if (win_line) begin
          if (sub == SUB_LAST) begin
            sub <= '0;
            if (row != 6'd63) row <= row + 6'd1;  // saturate: no wrap mid-frame
          end else begin
            sub <= sub + 3'd1;
          end
        end
      end
    end
  end

  always_comb begin
    ctl0     = '0;
    ctl0.de  = (hcnt < HA) && (vcnt < VA);
    ctl0.hs  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    ctl0.vs  = (vcnt >= VS_BEG) && (vcnt < VS_END);
    ctl0.fs  = (hcnt == '0) && (vcnt == '0);
    ctl0.win = in_win;
    ctl0.sel = hcnt[1:0];
  end

  // Stages 1-2: VRAM address issue, control delay line, per-frame screen enable
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_rp_a    <= '0;
      ctl_pipe     <= '0;
      lcd_on_frame <= 1'b0;
    end else begin
      vram_rp_a <= in_win ? {row, hcnt[9:2]} : 14'd0;
      ctl_pipe  <= {ctl_pipe[1], ctl0};
      if (ctl0.fs) lcd_on_frame <= lcd_on;
    end
  end

  // Stage 3: output register, aligned with the returned nibble
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      pix         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync_n     <= ~ctl_pipe[2].hs;
      vsync_n     <= ~ctl_pipe[2].vs;
      de          <= ctl_pipe[2].de;
      frame_start <= ctl_pipe[2].fs;
      pix         <= vram_rp_do[ctl_pipe[2].sel] & ctl_pipe[2].win & lcd_on_frame;
    end
  end

endmodule
